// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Package  : seg_pkg
// Summary  : Shared constants and helpers for the seven-segment scan path:
//            blank pattern, digit glyphs (active-high, bit0 = segment a) and
//            the slot-index width helper.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // All segments and the decimal point off (pins are active-low)
  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high glyphs, bit order g..a
  localparam logic [6:0] SEG_PAT_0 = 7'h3F;
  localparam logic [6:0] SEG_PAT_1 = 7'h06;
  localparam logic [6:0] SEG_PAT_2 = 7'h5B;
  localparam logic [6:0] SEG_PAT_3 = 7'h4F;
  localparam logic [6:0] SEG_PAT_4 = 7'h66;
  localparam logic [6:0] SEG_PAT_5 = 7'h6D;
  localparam logic [6:0] SEG_PAT_6 = 7'h7D;
  localparam logic [6:0] SEG_PAT_7 = 7'h07;
  localparam logic [6:0] SEG_PAT_8 = 7'h7F;
  localparam logic [6:0] SEG_PAT_9 = 7'h6F;
  localparam logic [6:0] SEG_PAT_A = 7'h77;
  localparam logic [6:0] SEG_PAT_B = 7'h7C;
  localparam logic [6:0] SEG_PAT_C = 7'h39;
  localparam logic [6:0] SEG_PAT_D = 7'h5E;
  localparam logic [6:0] SEG_PAT_E = 7'h79;
  localparam logic [6:0] SEG_PAT_F = 7'h71;

  // Middle bar only: shown for 10..15 in decimal mode
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Width of a slot index; a single-digit display still needs one bit
  function automatic int slot_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_decoder
// Summary  : Combinational nibble to seven-segment decoder. Produces the
//            active-low g..a pattern; hex_mode selects A-F glyphs, otherwise
//            values 10..15 render as a dash.
// Revision : 1.0 - initial release
// ============================================================================
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg_n
);

  logic [6:0] pat;

  // Glyph lookup in active-high form, inverted once at the output
  always_comb begin
    pat = SEG_DASH;
    case (nibble)
      4'h0:    pat = SEG_PAT_0;
      4'h1:    pat = SEG_PAT_1;
      4'h2:    pat = SEG_PAT_2;
      4'h3:    pat = SEG_PAT_3;
      4'h4:    pat = SEG_PAT_4;
      4'h5:    pat = SEG_PAT_5;
      4'h6:    pat = SEG_PAT_6;
      4'h7:    pat = SEG_PAT_7;
      4'h8:    pat = SEG_PAT_8;
      4'h9:    pat = SEG_PAT_9;
      4'hA:    pat = hex_mode ? SEG_PAT_A : SEG_DASH;
      4'hB:    pat = hex_mode ? SEG_PAT_B : SEG_DASH;
      4'hC:    pat = hex_mode ? SEG_PAT_C : SEG_DASH;
      4'hD:    pat = hex_mode ? SEG_PAT_D : SEG_DASH;
      4'hE:    pat = hex_mode ? SEG_PAT_E : SEG_DASH;
      4'hF:    pat = hex_mode ? SEG_PAT_F : SEG_DASH;
      default: pat = SEG_DASH;
    endcase
  end

  assign seg_n = ~pat;

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Summary  : Multiplexed N-digit seven-segment scan driver. Double-buffered
//            digit data captured only at frame boundaries (load/load_ack),
//            hex/decimal decode, per-digit blank and decimal point, PWM
//            brightness with a one-cycle dead time at every slot start.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int PWM_W      = 8
) (
  input  logic                    CLK100MHZ,
  input  logic                    RESET_BTN,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    hex_mode,
  input  logic                    load,
  output logic                    load_ack,
  input  logic [PWM_W-1:0]        pwm_in,
  output logic [7:0]              SevenSegment,
  output logic [NUM_DIGITS-1:0]   SegmentDrivers,
  output logic                    scan_tick
);

  localparam int SLOT_W   = slot_width(NUM_DIGITS);
  localparam int PS_W_MIN = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // The prescaler must be at least PWM_W wide so its low bits can serve
  // directly as the PWM counter.
  localparam int PS_W     = (PS_W_MIN > PWM_W) ? PS_W_MIN : PWM_W;

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  // Scan timing state
  logic [PS_W-1:0]         prescaler_q, prescaler_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [PWM_W-1:0]        pwm_q, pwm_d;

  // Shadow (displayed) copy of the requester's data
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic                    hex_q, hex_d;

  // Registered pin drive
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   drv_q, drv_d;

  // Per-cycle decode of the current slot
  logic                    slot_end;
  logic                    frame_end;
  logic                    capture;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   drv_sel_n;
  logic [6:0]              glyph_n;
  logic [PWM_W-1:0]        pwm_cnt;
  logic                    drive_en;

  assign slot_end  = (prescaler_q == PS_LAST);
  assign frame_end = slot_end && (slot_q == SLOT_LAST);
  assign capture   = load && frame_end;

  assign load_ack  = capture;
  assign scan_tick = slot_end;

  // Prescaler/slot advance; brightness is latched as each slot begins
  always_comb begin
    prescaler_d = prescaler_q + PS_W'(1);
    slot_d      = slot_q;
    pwm_d       = pwm_q;
    if (slot_end) begin
      prescaler_d = '0;
      pwm_d       = pwm_in;
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + SLOT_W'(1);
      end
    end
  end

  // Shadow registers only change at the frame boundary, so a frame never tears
  always_comb begin
    digits_d = digits_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    hex_d    = hex_q;
    if (capture) begin
      digits_d = digits_in;
      dp_d     = dp_in;
      blank_d  = blank_in;
      hex_d    = hex_mode;
    end
  end

  // Select the active slot's digit data and its active-low driver bit
  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    drv_sel_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        cur_digit    = digits_q[4*i +: 4];
        cur_dp       = dp_q[i];
        cur_blank    = blank_q[i];
        drv_sel_n[i] = 1'b0;
      end
    end
  end

  seg_decoder u_decoder (
    .nibble   (cur_digit),
    .hex_mode (hex_q),
    .seg_n    (glyph_n)
  );

  assign pwm_cnt = prescaler_q[PWM_W-1:0];

  // Prescaler 0 is the dead-time cycle separating adjacent digits
  assign drive_en = (prescaler_q != '0) && (pwm_cnt <= pwm_q) && !cur_blank;

  // Next pin values: lit digit when enabled, everything dark otherwise
  always_comb begin
    seg_d = SEG_OFF;
    drv_d = '1;
    if (drive_en) begin
      seg_d = {~cur_dp, glyph_n};
      drv_d = drv_sel_n;
    end
  end

  // State registers; reset leaves the display dark until the first load
  always_ff @(posedge CLK100MHZ or negedge RESET_BTN) begin
    if (!RESET_BTN) begin
      prescaler_q <= '0;
      slot_q      <= '0;
      pwm_q       <= '0;
      digits_q    <= '0;
      dp_q        <= '0;
      blank_q     <= '1;
      hex_q       <= 1'b0;
      seg_q       <= SEG_OFF;
      drv_q       <= '1;
    end else begin
      prescaler_q <= prescaler_d;
      slot_q      <= slot_d;
      pwm_q       <= pwm_d;
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      blank_q     <= blank_d;
      hex_q       <= hex_d;
      seg_q       <= seg_d;
      drv_q       <= drv_d;
    end
  end

  assign SevenSegment   = seg_q;
  assign SegmentDrivers = drv_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Summary  : Scoreboard bench for seg_scan_driver (4 digits, 8-cycle slots,
//            2-bit PWM). Stimulus pushes per-cycle expected pin values for
//            each frame; a monitor pops and compares them on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

  logic        CLK100MHZ = 1'b0;
  logic        RESET_BTN = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in     = '0;
  logic [3:0]  blank_in  = '0;
  logic        hex_mode  = 1'b0;
  logic        load      = 1'b0;
  logic [1:0]  pwm_in    = '0;
  logic        load_ack;
  logic [7:0]  SevenSegment;
  logic [3:0]  SegmentDrivers;
  logic        scan_tick;

  seg_scan_driver #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .PWM_W      (2)
  ) dut (
    .CLK100MHZ      (CLK100MHZ),
    .RESET_BTN      (RESET_BTN),
    .digits_in      (digits_in),
    .dp_in          (dp_in),
    .blank_in       (blank_in),
    .hex_mode       (hex_mode),
    .load           (load),
    .load_ack       (load_ack),
    .pwm_in         (pwm_in),
    .SevenSegment   (SevenSegment),
    .SegmentDrivers (SegmentDrivers),
    .scan_tick      (scan_tick)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  // Clock edges since reset release; equals the DUT's scan state index
  int t = 0;
  always @(posedge CLK100MHZ) begin
    if (!RESET_BTN) t <= 0;
    else            t <= t + 1;
  end

  typedef struct {
    int         t;      // -1: check immediately on async_ev
    logic [7:0] seg;
    logic [3:0] drv;
    logic       ack;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   flush  = 1'b0;
  event async_ev;

  // Expected output for state cycles F..F+n-1 (seen one cycle later).
  // act: prescaler values at which the PWM lets the digit drive.
  task automatic push_frame(input int F, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3,
                            input logic [3:0] blank, input logic [7:0] act,
                            input bit ack_end, input int n);
    logic [7:0] sv [4];
    logic [3:0] one;
    exp_t       e;
    int         s, p;
    bit         en;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    one = 4'b0001;
    for (int c = 0; c < n; c++) begin
      s     = c / 8;
      p     = c % 8;
      en    = act[p] && !blank[s];
      e.t   = F + c + 1;
      e.seg = en ? sv[s] : 8'hFF;
      e.drv = en ? ~(one << s) : 4'hF;
      e.tick = (((F + c + 1) % 8) == 7);
      e.ack  = ack_end && (c == 30);
      q.push_back(e);
    end
  endtask

  task automatic push_dark(input int F, input bit ack_end);
    push_frame(F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF, 8'hFE, ack_end, 32);
  endtask

  task automatic wait_t(input int n);
    int guard;
    guard = 0;
    while (t != n) begin
      @(posedge CLK100MHZ);
      #1;
      guard++;
      if (guard > 5000) begin
        $display("FAIL wait_t: t=%0d never reached %0d", t, n);
        $fatal(1, "bench stalled");
      end
    end
  endtask

  // Monitor: compare the head entry whose time has come
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK100MHZ or async_ev);
      while (q.size() > 0) begin
        if (flush || (q[0].t != -1 && q[0].t < t)) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missed t=%0d: no sample taken, expected seg=%h drv=%b", e.t, e.seg, e.drv);
        end else if (q[0].t == -1 || q[0].t == t) begin
          e = q.pop_front();
          checks++;
          if (SevenSegment !== e.seg || SegmentDrivers !== e.drv ||
              load_ack !== e.ack || scan_tick !== e.tick) begin
            errors++;
            $display("FAIL pins t=%0d: got seg=%h drv=%b ack=%b tick=%b, expected seg=%h drv=%b ack=%b tick=%b",
                     e.t, SevenSegment, SegmentDrivers, load_ack, scan_tick,
                     e.seg, e.drv, e.ack, e.tick);
          end
        end else begin
          break;
        end
      end
    end
  end

  // Stimulus
  initial begin
    exp_t e;
    int   guard;
    repeat (3) @(negedge CLK100MHZ);
    #1 RESET_BTN = 1'b1;

    // Three dark frames with no load, then a load during frame 3
    push_dark(0, 1'b0);
    wait_t(32);  push_dark(32, 1'b0);
    wait_t(64);  push_dark(64, 1'b0);
    wait_t(96);  push_dark(96, 1'b1);
    digits_in = 16'h1234; dp_in = 4'b0000; blank_in = 4'b0000;
    hex_mode = 1'b0; pwm_in = 2'd3; load = 1'b1;

    // "1234" full brightness; new data requested mid-slot 1 must wait
    wait_t(128); load = 1'b0;
    push_frame(128, 8'h99, 8'hB0, 8'hA4, 8'hF9, 4'b0000, 8'hFE, 1'b1, 32);
    wait_t(139);
    digits_in = 16'h567A; dp_in = 4'b0001; load = 1'b1;

    // Decimal mode: A shows dash with DP
    wait_t(160); load = 1'b0;
    push_frame(160, 8'h3F, 8'hF8, 8'h82, 8'h92, 4'b0000, 8'hFE, 1'b1, 32);
    wait_t(170);
    hex_mode = 1'b1; blank_in = 4'b0100; load = 1'b1;
    wait_t(191); pwm_in = 2'd1;

    // Hex mode, digit 2 blanked, pwm=1; a short load pulse must be ignored
    wait_t(192); load = 1'b0;
    push_frame(192, 8'h08, 8'hF8, 8'h82, 8'h92, 4'b0100, 8'h32, 1'b0, 32);
    wait_t(200);
    digits_in = 16'h0000; dp_in = 4'b0000; blank_in = 4'b0000; hex_mode = 1'b0; load = 1'b1;
    wait_t(205); load = 1'b0;
    wait_t(223); pwm_in = 2'd0;

    // pwm=0: only prescaler 4 drives; reload same data unblanked
    wait_t(224);
    push_frame(224, 8'h08, 8'hF8, 8'h82, 8'h92, 4'b0100, 8'h10, 1'b1, 32);
    wait_t(230);
    digits_in = 16'h567A; dp_in = 4'b0001; blank_in = 4'b0000; hex_mode = 1'b1; load = 1'b1;
    wait_t(255); pwm_in = 2'd3;

    // Frame cut short by asynchronous reset in slot 2
    wait_t(256); load = 1'b0;
    push_frame(256, 8'h08, 8'hF8, 8'h82, 8'h92, 4'b0000, 8'hFE, 1'b0, 19);
    wait_t(275);
    #6 RESET_BTN = 1'b0;
    #1;
    e.t = -1; e.seg = 8'hFF; e.drv = 4'hF; e.ack = 1'b0; e.tick = 1'b0;
    q.push_back(e);
    -> async_ev;
    repeat (3) @(negedge CLK100MHZ);
    #1 RESET_BTN = 1'b1;

    // Dark after reset until the next acknowledged load; then hex C..F
    push_dark(0, 1'b0);
    wait_t(32); push_dark(32, 1'b1);
    digits_in = 16'hFEDC; dp_in = 4'b1000; blank_in = 4'b0000;
    hex_mode = 1'b1; load = 1'b1;
    wait_t(64); load = 1'b0;
    push_frame(64, 8'hC6, 8'hA1, 8'h86, 8'h0E, 4'b0000, 8'hFE, 1'b0, 32);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge CLK100MHZ);
      guard++;
    end
    #1;
    if (q.size() > 0) begin
      flush = 1'b1;
      -> async_ev;
      #1;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed seven-segment scan driver for the WallClock display path, generalising its fixed 4-digit scan.
- Features: N digits, double-buffered digit data with a frame-aligned load handshake, hex/decimal decode modes, per-digit blanking and decimal points, PWM brightness with inter-digit dead time.
- Clock-domain logic (time counting) presents values here; this block owns the SevenSegment and SegmentDrivers pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (1..16).
- SCAN_DIV, 100000, CLK100MHZ cycles per digit slot (>=2).
- PWM_W, 8, brightness resolution in bits.

Ports:
- CLK100MHZ  in  1  system clock.
- RESET_BTN  in  1  reset, asynchronous, active-low.
- digits_in  in  4*NUM_DIGITS  nibble per digit; digit 0 (rightmost) at [3:0].
- dp_in  in  NUM_DIGITS  decimal point enable per digit, active-high.
- blank_in  in  NUM_DIGITS  blank digit, active-high.
- hex_mode  in  1  1 = hex decode A-F; 0 = decimal, values 10-15 show dash.
- load  in  1  level request to capture digits_in/dp_in/blank_in/hex_mode.
- load_ack  out  1  one-cycle pulse when capture occurs.
- pwm_in  in  PWM_W  brightness.
- SevenSegment  out  8  active-low; [7]=DP, [6:0]=g..a.
- SegmentDrivers  out  NUM_DIGITS  active-low one-hot digit enable.
- scan_tick  out  1  one-cycle pulse at every slot advance.

Behaviour:
- Reset (RESET_BTN=0, async):
  - prescaler=0, slot=0.
  - Shadow digits=0, dp=0, blank=all ones, hex_mode=0.
  - SevenSegment=8'hFF, SegmentDrivers=all ones, load_ack=0, scan_tick=0.
  - Display stays dark until the first load.
- Prescaler counts 0..SCAN_DIV-1 and wraps. At SCAN_DIV-1, slot increments; slot wraps NUM_DIGITS-1 -> 0. scan_tick=1 in that same cycle.
- Frame boundary: the cycle where prescaler=SCAN_DIV-1 and slot=NUM_DIGITS-1.
- Load handshake:
  - If load=1 at a frame boundary, shadow registers capture all inputs and load_ack pulses that cycle.
  - New data is visible from slot 0 of the next frame. No tearing within a frame.
  - The requester holds load until ack.
  - load held continuously captures once per frame. load dropped before a boundary is not captured.
- pwm_in is sampled into pwm_q at each slot start.
- pwm_cnt = prescaler mod 2^PWM_W.
- Drive enable = (prescaler!=0) AND (pwm_cnt <= pwm_q) AND NOT blank[slot]. prescaler==0 is the dead-time cycle.
- Enabled:
  - SegmentDrivers has bit slot = 0, all others 1.
  - SevenSegment = {~dp[slot], ~decode(digit[slot])}.
- Disabled: SegmentDrivers all ones, SevenSegment=8'hFF.
- Outputs are registered: SevenSegment/SegmentDrivers in cycle k+1 reflect prescaler/slot/shadow state of cycle k.
- Decode (a=bit0), active-high pattern before inversion:
  - 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F.
  - Hex: A 77, b 7C, C 39, d 5E, E 79, F 71.
  - Decimal mode, 10-15: 40 (dash).
- NUM_DIGITS=1: every slot advance is a frame boundary.

Decomposition:
- Package seg_pkg:
  - SEG_OFF=8'hFF.
  - Digit pattern constants.
  - Dash pattern constant.
  - Width helper for slot index ($clog2(NUM_DIGITS), min 1).
- Sub-module seg_decoder: combinational nibble+hex_mode -> 7-bit active-low pattern, shared with the WallClock top.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, PWM_W=2 unless noted):
- Reset, no load for 3 frames -> SevenSegment=8'hFF, SegmentDrivers=4'hF, load_ack never 1, scan_tick every 8 cycles.
- load with digits_in=16'h1234, dp_in=0, blank_in=0, pwm_in=3 -> load_ack at first frame boundary. Next frame:
  - slot0: SegmentDrivers=4'b1110, SevenSegment=8'h99.
  - slot1: 4'b1101, 8'hB0.
  - slot2: 4'b1011, 8'hA4.
  - slot3: 4'b0111, 8'hF9.
  - Each slot has 7 active cycles.
- digit0=4'hA, dp_in[0]=1:
  - hex_mode=0 -> SevenSegment=8'h3F.
  - hex_mode=1 -> 8'h08.
- load raised during slot 1 with new data -> no ack until slot3/prescaler=7. Old data shown for the rest of the frame; new data from next slot 0.
- pwm_in=1 -> per slot, driver active only at prescaler 1,4,5 (3 of 8). pwm_in=0 -> active at prescaler 4 only. blank_in[2]=1 -> slot 2 never active.
- Reset asserted mid-slot 2 -> outputs 8'hFF/4'hF in the same cycle without a clock edge. After release, dark until the next load is acked.
